alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
- Execute-stage ALU for the pipelined MIPS-32 core. It is the consumer end of the 4-bit ALUCtl code produced by the ALU control decoder.
- Takes ALUCtl plus two operands and a destination tag, computes the result, and holds it in a 2-entry output buffer feeding the EX/MEM boundary.
- Uses a valid/ready handshake on both sides so that MEM-side stalls backpressure EX without losing results.
- Flags illegal control codes, including the decoder's default value 15.

Parameters:
- WIDTH, 32, operand/result width in bits
- TAGW, 5, destination-register tag width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush (branch mispredict); drops buffered and same-cycle results
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept an operation this cycle
- alu_ctl  input  4  operation code
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- in_tag  input  TAGW  destination register tag
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- result  output  WIDTH  head entry result
- zero  output  1  head entry result == 0
- overflow  output  1  head entry signed overflow (ADD/SUB only)
- out_tag  output  TAGW  head entry tag
- out_illegal  output  1  head entry had an unsupported alu_ctl
- illegal_sticky  output  1  set on any accepted illegal op; cleared only by reset

Behaviour:
- Opcode map (must match the decoder):
  - 0 AND
  - 1 OR
  - 2 ADD (wraps mod 2^WIDTH)
  - 6 SUB (A-B, wraps)
  - 7 SLT (signed compare, result 1 or 0, zero-extended)
  - 12 NOR
  - Any other code: result 0, zero=1, overflow=0, out_illegal=1.
- Overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Storage: 2-entry FIFO with occupancy count 0..2.
  - in_ready = (count < 2), driven from registered count only; no combinational path from out_ready.
  - out_valid = (count != 0). Head outputs come directly from the head entry register.
- Latency: an op accepted in cycle N appears at the outputs in cycle N+1 when the buffer was empty. Ordering is strictly FIFO.
- Simultaneous push and pop at count 1: count stays 1, the pushed entry becomes head in the next cycle.
- At count 2: in_ready=0. A pop frees one slot next cycle.
- At count 0: a pop attempt is impossible (out_valid=0).
- Outputs are stable while out_valid && !out_ready.
- Flush:
  - Next cycle: count=0, out_valid=0.
  - Any same-cycle accept is discarded.
  - illegal_sticky is not set by an op accepted in the flush cycle, and is not cleared by flush.
- Reset (overrides flush and all handshakes, including mid-stream):
  - count=0, out_valid=0, in_ready=1 in the cycle after reset.
  - result=0, zero=0, overflow=0, out_tag=0, out_illegal=0, illegal_sticky=0.
  - Entry storage is cleared.

Test Plan:
- Reset, then ADD A=5 B=7 tag=3 with out_ready=1 -> next cycle out_valid=1, result=12, zero=0, overflow=0, out_tag=3.
- SUB A=0x7FFFFFFF B=0xFFFFFFFF -> result=0x80000000, overflow=1. ADD A=0x7FFFFFFF B=1 -> result=0x80000000, overflow=1. SLT A=0xFFFFFFFF B=1 -> result=1. NOR A=0 B=0 -> 0xFFFFFFFF.
- out_ready=0, issue AND then OR back-to-back -> count=2, in_ready=0 in cycle 3. Hold 3 cycles: head stays the AND result. Then out_ready=1 -> AND, OR delivered in order; in_ready returns to 1 one cycle after the first pop.
- count=1 with simultaneous push (SUB 9-9) and pop -> count stays 1; next head result=0, zero=1.
- alu_ctl=15 A=3 B=4 -> result=0, zero=1, out_illegal=1, illegal_sticky=1. Sticky stays 1 after subsequent legal ops and after flush; cleared only by reset.
- count=2 plus a pending input, assert flush -> next cycle out_valid=0, in_ready=1, flushed-cycle op never appears. Repeat with reset asserted instead -> all outputs 0.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the execute-stage ALU.
//   master: operation producer and result consumer (decode/MEM side)
//   slave : the ALU stage itself
// Signals:
//   in_valid/in_ready         operation handshake
//   alu_ctl/src_a/src_b/in_tag operation payload
//   out_valid/out_ready       result handshake
//   result/zero/overflow/out_tag/out_illegal  head-entry payload
//   illegal_sticky            latched "an illegal op was accepted"
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [TAGW-1:0]  out_tag;
  logic             out_illegal;
  logic             illegal_sticky;

  modport master (
    output in_valid, alu_ctl, src_a, src_b, in_tag, out_ready,
    input  in_ready, out_valid, result, zero, overflow, out_tag, out_illegal, illegal_sticky
  );

  modport slave (
    input  in_valid, alu_ctl, src_a, src_b, in_tag, out_ready,
    output in_ready, out_valid, result, zero, overflow, out_tag, out_illegal, illegal_sticky
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry output buffer toward the EX/MEM boundary.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; overrides flush and handshakes
//   flush  synchronous pipeline flush; drops buffered and same-cycle results
//   bus    alu_exec_stage_if.slave: operation in, result out (valid/ready both sides)
// in_ready depends only on the registered occupancy, so there is no combinational
// path from out_ready to in_ready.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  alu_exec_stage_if.slave bus
);

  localparam logic [3:0] CtlAnd = 4'd0;
  localparam logic [3:0] CtlOr  = 4'd1;
  localparam logic [3:0] CtlAdd = 4'd2;
  localparam logic [3:0] CtlSub = 4'd6;
  localparam logic [3:0] CtlSlt = 4'd7;
  localparam logic [3:0] CtlNor = 4'd12;

  typedef struct packed {
    logic             illegal;
    logic             ovf;
    logic             zero;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] res;
  } entry_t;

  entry_t     ent_q [2];  // ent_q[0] is always the head
  entry_t     ent_new;
  logic [1:0] count_q, count_d;
  logic       sticky_q;
  logic       push, pop;

  logic [WIDTH-1:0] sum, diff;
  logic             sign_a, sign_b;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign sum    = bus.src_a + bus.src_b;
  assign diff   = bus.src_a - bus.src_b;
  assign sign_a = bus.src_a[WIDTH-1];
  assign sign_b = bus.src_b[WIDTH-1];

  always_comb begin
    ent_new     = '0;
    ent_new.tag = bus.in_tag;
    case (bus.alu_ctl)
      CtlAnd: ent_new.res = bus.src_a & bus.src_b;
      CtlOr:  ent_new.res = bus.src_a | bus.src_b;
      CtlAdd: begin
        ent_new.res = sum;
        ent_new.ovf = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      CtlSub: begin
        ent_new.res = diff;
        ent_new.ovf = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      CtlSlt: ent_new.res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      CtlNor: ent_new.res = ~(bus.src_a | bus.src_b);
      default: ent_new.illegal = 1'b1;
    endcase
    ent_new.zero = (ent_new.res == '0);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      sticky_q <= 1'b0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push && ent_new.illegal) begin
        sticky_q <= 1'b1;
      end
      if (pop) begin
        ent_q[0] <= ent_q[1];
      end
      // Push lands in the head slot when the buffer is (or is becoming) empty at the head.
      if (push) begin
        if (count_q == 2'd0 || pop) begin
          ent_q[0] <= ent_new;
        end else begin
          ent_q[1] <= ent_new;
        end
      end
    end
  end

  assign bus.result         = ent_q[0].res;
  assign bus.zero           = ent_q[0].zero;
  assign bus.overflow       = ent_q[0].ovf;
  assign bus.out_tag        = ent_q[0].tag;
  assign bus.out_illegal    = ent_q[0].illegal;
  assign bus.illegal_sticky = sticky_q;

endmodule
